// File: rtl/printer_alarm_annunciator.sv
// Printer alarm annunciator: synchronise, debounce and acknowledge three
// alarm lines, driving blinking/steady lamps, a buzzer and an irq pulse.
module printer_alarm_annunciator #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int BLINK_DIV       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] alarm_in,
   input  logic       ack,
   output logic [2:0] lamp,
   output logic       buzzer,
   output logic [2:0] unack,
   output logic       irq
);

   typedef enum logic [1:0] {
      ST_NORMAL      = 2'd0,
      ST_ALARM_UNACK = 2'd1,
      ST_ALARM_ACK   = 2'd2,
      ST_RTN_UNACK   = 2'd3
   } state_e;

   localparam logic [7:0]  DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [15:0] BLINK_LAST = 16'(BLINK_DIV - 1);

   logic [2:0]  s1_q, s1_d;
   logic [2:0]  s2_q, s2_d;
   logic [2:0]  filt_q, filt_d;
   logic [7:0]  cnt_q [3];
   logic [7:0]  cnt_d [3];
   state_e      state_q [3];
   state_e      state_d [3];
   logic [15:0] blink_cnt_q, blink_cnt_d;
   logic        blink_phase_q, blink_phase_d;
   logic        enter_q, enter_d;
   logic        irq_q, irq_d;

   always_comb begin
      s1_d          = alarm_in;
      s2_d          = s1_q;
      filt_d        = filt_q;
      enter_d       = 1'b0;
      irq_d         = enter_q;
      blink_cnt_d   = blink_cnt_q + 16'd1;
      blink_phase_d = blink_phase_q;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i]   = cnt_q[i];
         state_d[i] = state_q[i];
      end

      if (blink_cnt_q == BLINK_LAST) begin
         blink_cnt_d   = 16'd0;
         blink_phase_d = ~blink_phase_q;
      end

      for (int i = 0; i < 3; i++) begin
         if (s2_q[i] == filt_q[i]) begin
            cnt_d[i] = 8'd0;
         end else if (cnt_q[i] == DB_LAST) begin
            filt_d[i] = s2_q[i];
            cnt_d[i]  = 8'd0;
         end else begin
            cnt_d[i] = cnt_q[i] + 8'd1;
         end

         unique case (state_q[i])
            ST_NORMAL: begin
               if (filt_q[i]) state_d[i] = ST_ALARM_UNACK;
            end
            ST_ALARM_UNACK: begin
               if (ack) state_d[i] = filt_q[i] ? ST_ALARM_ACK : ST_NORMAL;
               else if (!filt_q[i]) state_d[i] = ST_RTN_UNACK;
            end
            ST_ALARM_ACK: begin
               if (!filt_q[i]) state_d[i] = ST_NORMAL;
            end
            ST_RTN_UNACK: begin
               // A re-alarm outranks an acknowledge of the old return.
               if (filt_q[i]) state_d[i] = ST_ALARM_UNACK;
               else if (ack) state_d[i] = ST_NORMAL;
            end
            default: state_d[i] = ST_NORMAL;
         endcase

         if (state_d[i] == ST_ALARM_UNACK &&
             (state_q[i] == ST_NORMAL || state_q[i] == ST_RTN_UNACK))
            enter_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q          <= '0;
         s2_q          <= '0;
         filt_q        <= '0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         enter_q       <= 1'b0;
         irq_q         <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i]   <= '0;
            state_q[i] <= ST_NORMAL;
         end
      end else begin
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         filt_q        <= filt_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         enter_q       <= enter_d;
         irq_q         <= irq_d;
         for (int i = 0; i < 3; i++) begin
            cnt_q[i]   <= cnt_d[i];
            state_q[i] <= state_d[i];
         end
      end
   end

   always_comb begin
      lamp   = '0;
      unack  = '0;
      buzzer = 1'b0;
      for (int i = 0; i < 3; i++) begin
         unique case (state_q[i])
            ST_NORMAL:      lamp[i] = 1'b0;
            ST_ALARM_UNACK: lamp[i] = blink_phase_q;
            ST_ALARM_ACK:   lamp[i] = 1'b1;
            ST_RTN_UNACK:   lamp[i] = blink_phase_q;
            default:        lamp[i] = 1'b0;
         endcase
         unack[i] = (state_q[i] == ST_ALARM_UNACK) ||
                    (state_q[i] == ST_RTN_UNACK);
         if (state_q[i] == ST_ALARM_UNACK) buzzer = 1'b1;
      end
   end

   assign irq = irq_q;

endmodule

// File: tb/tb_printer_alarm_annunciator.sv
// Scoreboard bench for printer_alarm_annunciator against a cycle-level
// behavioural model of synchroniser, debounce, ack FSM and blink timing.
module tb_printer_alarm_annunciator;

   localparam int DB = 4;
   localparam int BD = 8;
   localparam int N  = 0;
   localparam int AU = 1;
   localparam int AA = 2;
   localparam int RU = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [2:0] alarm_in = 3'b000;
   logic       ack = 1'b0;
   logic [2:0] lamp;
   logic       buzzer;
   logic [2:0] unack;
   logic       irq;

   printer_alarm_annunciator #(
      .DEBOUNCE_CYCLES(DB),
      .BLINK_DIV(BD)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .alarm_in(alarm_in),
      .ack(ack),
      .lamp(lamp),
      .buzzer(buzzer),
      .unack(unack),
      .irq(irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] lamp;
      logic       buzzer;
      logic [2:0] unack;
      logic       irq;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;

   int ms1[3], ms2[3], mf[3], mrun[3], mst[3];
   int menter, mirq, medges;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int c = 0; c < 3; c++) begin
         ms1[c] = 0; ms2[c] = 0; mf[c] = 0; mrun[c] = 0; mst[c] = N;
      end
      menter = 0; mirq = 0; medges = 0;
   endfunction

   function automatic void model_step(input logic [2:0] a, input logic k);
      int nst;
      int ent;
      ent = 0;
      for (int c = 0; c < 3; c++) begin
         case (mst[c])
            N:  nst = (mf[c] != 0) ? AU : N;
            AU: if (k) nst = (mf[c] != 0) ? AA : N;
                else nst = (mf[c] != 0) ? AU : RU;
            AA: nst = (mf[c] != 0) ? AA : N;
            default: nst = (mf[c] != 0) ? AU : (k ? N : RU);
         endcase
         if (nst == AU && (mst[c] == N || mst[c] == RU)) ent = 1;
         if (ms2[c] != mf[c]) begin
            if (mrun[c] + 1 >= DB) begin
               mf[c] = ms2[c];
               mrun[c] = 0;
            end else begin
               mrun[c]++;
            end
         end else begin
            mrun[c] = 0;
         end
         ms2[c] = ms1[c];
         ms1[c] = int'(a[c]);
         mst[c] = nst;
      end
      mirq = menter;
      menter = ent;
      medges++;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      int ph;
      ph = (medges / BD) % 2;
      e.lamp = '0; e.unack = '0; e.buzzer = 1'b0;
      e.irq = (mirq != 0);
      for (int c = 0; c < 3; c++) begin
         if (mst[c] == AA) e.lamp[c] = 1'b1;
         else if (mst[c] == AU || mst[c] == RU) e.lamp[c] = (ph != 0);
         if (mst[c] == AU || mst[c] == RU) e.unack[c] = 1'b1;
         if (mst[c] == AU) e.buzzer = 1'b1;
      end
      return e;
   endfunction

   // Called from the low phase; returns at the next falling edge.
   task automatic drive(input logic [2:0] a, input logic k);
      alarm_in = a;
      ack = k;
      model_step(a, k);
      q.push_back(model_out());
      @(negedge clk);
   endtask

   task automatic mid_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("rst_lamp", int'(lamp), 0);
      chk("rst_buzzer", int'(buzzer), 0);
      chk("rst_unack", int'(unack), 0);
      chk("rst_irq", int'(irq), 0);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("lamp", int'(lamp), int'(e.lamp));
            chk("buzzer", int'(buzzer), int'(e.buzzer));
            chk("unack", int'(unack), int'(e.unack));
            chk("irq", int'(irq), int'(e.irq));
         end
      end
   end

   initial begin : stim
      int hold[3];
      logic [2:0] a;
      int irqs;
      alarm_in = 3'b100;
      #2;
      chk("reset_out", int'({lamp, buzzer, unack, irq}), 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();

      for (int i = 0; i < 20; i++) begin
         drive(3'b100, 1'b0);
         chk("t1_unack", int'(unack), (medges >= 7) ? 4 : 0);
         chk("t1_irq", int'(irq), (medges == 8) ? 1 : 0);
      end
      drive(3'b100, 1'b1);
      chk("t3_lamp_ack", int'(lamp), 4);
      chk("t3_buzzer", int'(buzzer), 0);
      for (int i = 0; i < 7; i++) drive(3'b000, 1'b0);
      chk("t3_normal", int'(lamp), 0);

      for (int i = 0; i < 3; i++) drive(3'b010, 1'b0);
      for (int i = 0; i < 10; i++) begin
         drive(3'b000, 1'b0);
         chk("t2_glitch", int'({lamp, buzzer, unack, irq}), 0);
      end

      irqs = 0;
      for (int i = 0; i < 10; i++) begin
         drive(3'b110, 1'b0);
         irqs += int'(irq);
      end
      chk("t5_unack", int'(unack), 6);
      chk("t5_irqs", irqs, 1);
      for (int i = 0; i < 12; i++) drive(3'b000, 1'b1);

      for (int i = 0; i < 9; i++) drive(3'b111, 1'b0);
      mid_reset();
      irqs = 0;
      for (int i = 0; i < 10; i++) begin
         drive(3'b111, 1'b0);
         irqs += int'(irq);
         chk("t6_unack", int'(unack), (medges >= 7) ? 7 : 0);
      end
      chk("t6_irqs", irqs, 1);

      for (int i = 0; i < 10; i++) drive(3'b001, 1'b1);
      for (int i = 0; i < 10; i++) drive(3'b000, 1'b0);

      for (int c = 0; c < 3; c++) hold[c] = 0;
      a = 3'b000;
      for (int i = 0; i < 3000; i++) begin
         for (int c = 0; c < 3; c++) begin
            if (hold[c] == 0) begin
               a[c] = ~a[c];
               hold[c] = int'($urandom_range(1, 14));
            end
            hold[c]--;
         end
         if ($urandom_range(0, 499) == 0) mid_reset();
         drive(a, ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
      end

      for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
